// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter onto a single memory port.
// One burst outstanding downstream; the priority pointer alternates after each burst.
module axi_rd_arbiter #(
  parameter int ID_W       = 4,
  parameter int DATA_W     = 64,
  parameter int FIRST_PRIO = 0
) (
  input  logic              io_basic_ACLK,
  input  logic              io_basic_ARESETn,
  input  logic              m0_ARVALID,
  output logic              m0_ARREADY,
  input  logic [ID_W-1:0]   m0_ARID,
  input  logic [31:0]       m0_ARADDR,
  input  logic [7:0]        m0_ARLEN,
  input  logic [2:0]        m0_ARSIZE,
  input  logic [1:0]        m0_ARBURST,
  output logic              m0_RVALID,
  output logic [ID_W-1:0]   m0_RID,
  output logic [DATA_W-1:0] m0_RDATA,
  output logic [1:0]        m0_RRESP,
  output logic              m0_RLAST,
  input  logic              m0_RREADY,
  input  logic              m1_ARVALID,
  output logic              m1_ARREADY,
  input  logic [ID_W-1:0]   m1_ARID,
  input  logic [31:0]       m1_ARADDR,
  input  logic [7:0]        m1_ARLEN,
  input  logic [2:0]        m1_ARSIZE,
  input  logic [1:0]        m1_ARBURST,
  output logic              m1_RVALID,
  output logic [ID_W-1:0]   m1_RID,
  output logic [DATA_W-1:0] m1_RDATA,
  output logic [1:0]        m1_RRESP,
  output logic              m1_RLAST,
  input  logic              m1_RREADY,
  output logic              s_ARVALID,
  input  logic              s_ARREADY,
  output logic [ID_W-1:0]   s_ARID,
  output logic [31:0]       s_ARADDR,
  output logic [7:0]        s_ARLEN,
  output logic [2:0]        s_ARSIZE,
  output logic [1:0]        s_ARBURST,
  input  logic              s_RVALID,
  input  logic [ID_W-1:0]   s_RID,
  input  logic [DATA_W-1:0] s_RDATA,
  input  logic [1:0]        s_RRESP,
  input  logic              s_RLAST,
  output logic              s_RREADY,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } ar_t;

  localparam logic P0 = (FIRST_PRIO != 0);

  logic   clk;
  logic   rst_n;
  state_t state;
  state_t state_nxt;
  logic   prio;
  logic   grant;
  ar_t    ar_q;
  ar_t    ar_m0;
  ar_t    ar_m1;
  logic   pick;
  logic   in_idle;
  logic   in_data;
  logic   ar_hs;
  logic   r_done;
  logic   sel0;
  logic   sel1;

  assign clk   = io_basic_ACLK;
  assign rst_n = io_basic_ARESETn;

  assign ar_m0 = '{m0_ARID, m0_ARADDR, m0_ARLEN, m0_ARSIZE, m0_ARBURST};
  assign ar_m1 = '{m1_ARID, m1_ARADDR, m1_ARLEN, m1_ARSIZE, m1_ARBURST};

  // Pointer only matters on a tie; a lone requester always wins.
  assign pick    = (m0_ARVALID && m1_ARVALID) ? prio : m1_ARVALID;
  // Gated by reset so ARREADY stays low while reset is held.
  assign in_idle = (state == IDLE) && rst_n;
  assign in_data = (state == DATA);

  assign m0_ARREADY = in_idle && m0_ARVALID && !pick;
  assign m1_ARREADY = in_idle && m1_ARVALID && pick;
  assign ar_hs      = (m0_ARVALID && m0_ARREADY) ||
                      (m1_ARVALID && m1_ARREADY);

  assign sel0     = in_data && !grant;
  assign sel1     = in_data && grant;
  assign s_RREADY = (sel0 && m0_RREADY) || (sel1 && m1_RREADY);
  assign r_done   = in_data && s_RVALID && s_RREADY && s_RLAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= P0;
      grant <= 1'b0;
      ar_q  <= '0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        grant <= pick;
        ar_q  <= pick ? ar_m1 : ar_m0;
      end
      if (r_done) prio <= ~grant;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ar_hs) state_nxt = ADDR;
      ADDR:    if (s_ARREADY) state_nxt = DATA;
      DATA:    if (r_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_ARVALID = (state == ADDR);
  assign s_ARID    = ar_q.id;
  assign s_ARADDR  = ar_q.addr;
  assign s_ARLEN   = ar_q.len;
  assign s_ARSIZE  = ar_q.size;
  assign s_ARBURST = ar_q.burst;

  assign m0_RVALID = sel0 && s_RVALID;
  assign m0_RID    = sel0 ? s_RID   : '0;
  assign m0_RDATA  = sel0 ? s_RDATA : '0;
  assign m0_RRESP  = sel0 ? s_RRESP : '0;
  assign m0_RLAST  = sel0 && s_RLAST;

  assign m1_RVALID = sel1 && s_RVALID;
  assign m1_RID    = sel1 ? s_RID   : '0;
  assign m1_RDATA  = sel1 ? s_RDATA : '0;
  assign m1_RRESP  = sel1 ? s_RRESP : '0;
  assign m1_RLAST  = sel1 && s_RLAST;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter.
// Inputs change 1ns after the rising edge; checks follow a settle delay.
module tb_axi_rd_arbiter;

  localparam int ID_W = 4;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_ARVALID, m0_ARREADY, m1_ARVALID, m1_ARREADY;
  logic [ID_W-1:0]   m0_ARID, m1_ARID;
  logic [31:0]       m0_ARADDR, m1_ARADDR;
  logic [7:0]        m0_ARLEN, m1_ARLEN;
  logic [2:0]        m0_ARSIZE, m1_ARSIZE;
  logic [1:0]        m0_ARBURST, m1_ARBURST;
  logic              m0_RVALID, m1_RVALID, m0_RLAST, m1_RLAST;
  logic [ID_W-1:0]   m0_RID, m1_RID;
  logic [DATA_W-1:0] m0_RDATA, m1_RDATA;
  logic [1:0]        m0_RRESP, m1_RRESP;
  logic              m0_RREADY, m1_RREADY;
  logic              s_ARVALID, s_ARREADY;
  logic [ID_W-1:0]   s_ARID;
  logic [31:0]       s_ARADDR;
  logic [7:0]        s_ARLEN;
  logic [2:0]        s_ARSIZE;
  logic [1:0]        s_ARBURST;
  logic              s_RVALID, s_RLAST, s_RREADY, busy;
  logic [ID_W-1:0]   s_RID;
  logic [DATA_W-1:0] s_RDATA;
  logic [1:0]        s_RRESP;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_W(ID_W), .DATA_W(DATA_W), .FIRST_PRIO(0)) dut (
    .io_basic_ACLK(clk), .io_basic_ARESETn(rst_n),
    .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY), .m0_ARID(m0_ARID),
    .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE),
    .m0_ARBURST(m0_ARBURST), .m0_RVALID(m0_RVALID), .m0_RID(m0_RID),
    .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RREADY(m0_RREADY),
    .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY), .m1_ARID(m1_ARID),
    .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE),
    .m1_ARBURST(m1_ARBURST), .m1_RVALID(m1_RVALID), .m1_RID(m1_RID),
    .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RREADY(m1_RREADY),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARID(s_ARID),
    .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_RVALID(s_RVALID), .s_RID(s_RID),
    .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RREADY(s_RREADY), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    s_RVALID = 1'b1;
    s_RDATA  = d;
    s_RLAST  = last;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_ARVALID = 1'b1; m1_ARVALID = 1'b1;
    m0_ARID = '0; m0_ARADDR = '0; m0_ARLEN = '0;
    m0_ARSIZE = 3'd3; m0_ARBURST = 2'd1;
    m1_ARID = '0; m1_ARADDR = '0; m1_ARLEN = '0;
    m1_ARSIZE = 3'd3; m1_ARBURST = 2'd1;
    m0_RREADY = 1'b1; m1_RREADY = 1'b1;
    s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RID = 4'd5;
    s_RDATA = '0; s_RRESP = 2'd0; s_RLAST = 1'b0;
    tick; tick;
    chk("rst_m0_arready", 64'(m0_ARREADY), 0);
    chk("rst_m1_arready", 64'(m1_ARREADY), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_s_arvalid", 64'(s_ARVALID), 0);
    chk("rst_s_araddr", 64'(s_ARADDR), 0);
    chk("rst_s_rready", 64'(s_RREADY), 0);
    m0_ARVALID = 1'b0; m1_ARVALID = 1'b0;
    rst_n = 1'b1;
    tick;

    // m0 alone, 4-beat burst
    m0_ARVALID = 1'b1; m0_ARADDR = 32'h8000_0000;
    m0_ARLEN = 8'd3; m0_ARID = 4'd5;
    #1;
    chk("t1_m0_arready", 64'(m0_ARREADY), 1);
    chk("t1_m1_arready", 64'(m1_ARREADY), 0);
    chk("t1_busy_idle", 64'(busy), 0);
    chk("t1_s_arvalid_pre", 64'(s_ARVALID), 0);
    tick;
    m0_ARVALID = 1'b0; s_ARREADY = 1'b1;
    #1;
    chk("t1_s_arvalid", 64'(s_ARVALID), 1);
    chk("t1_s_araddr", 64'(s_ARADDR), 64'h8000_0000);
    chk("t1_s_arlen", 64'(s_ARLEN), 3);
    chk("t1_s_arid", 64'(s_ARID), 5);
    chk("t1_busy", 64'(busy), 1);
    tick;
    chk("t1_s_arvalid_off", 64'(s_ARVALID), 0);
    for (int b = 0; b < 4; b++) begin
      beat(64'(100 + b), b == 3);
      chk("t1_m0_rvalid", 64'(m0_RVALID), 1);
      chk("t1_m0_rdata", m0_RDATA, 64'(100 + b));
      chk("t1_m0_rlast", 64'(m0_RLAST), (b == 3) ? 64'd1 : 64'd0);
      chk("t1_m1_rvalid", 64'(m1_RVALID), 0);
      chk("t1_s_rready", 64'(s_RREADY), 1);
      tick;
    end
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    #1;
    chk("t1_busy_done", 64'(busy), 0);

    // stray downstream beat in IDLE
    s_RVALID = 1'b1;
    #1;
    chk("sp_s_rready", 64'(s_RREADY), 0);
    chk("sp_m0_rvalid", 64'(m0_RVALID), 0);
    chk("sp_m1_rvalid", 64'(m1_RVALID), 0);
    s_RVALID = 1'b0;
    tick;

    // fresh reset, simultaneous requests
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    m0_ARVALID = 1'b1; m0_ARADDR = 32'h1000; m0_ARLEN = 8'd0; m0_ARID = 4'd1;
    m1_ARVALID = 1'b1; m1_ARADDR = 32'h2000; m1_ARLEN = 8'd1; m1_ARID = 4'd2;
    #1;
    chk("t2_m0_arready", 64'(m0_ARREADY), 1);
    chk("t2_m1_arready", 64'(m1_ARREADY), 0);
    tick;
    m0_ARVALID = 1'b0;
    #1;
    chk("t2_addr_m0", 64'(s_ARADDR), 64'h1000);
    chk("t2_m1_stall", 64'(m1_ARREADY), 0);
    tick;
    beat(64'hA0, 1'b1);
    chk("t2_m0_rvalid", 64'(m0_RVALID), 1);
    chk("t2_m1_rvalid_off", 64'(m1_RVALID), 0);
    chk("t2_m1_stall_data", 64'(m1_ARREADY), 0);
    tick;
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    #1;
    chk("t2_idle_gap", 64'(busy), 0);
    chk("t2_m1_arready", 64'(m1_ARREADY), 1);
    tick;
    m1_ARVALID = 1'b0;
    #1;
    chk("t2_addr_m1", 64'(s_ARADDR), 64'h2000);
    chk("t2_id_m1", 64'(s_ARID), 2);
    tick;
    beat(64'hB0, 1'b0);
    chk("t2_m1_rvalid", 64'(m1_RVALID), 1);
    chk("t2_m1_rdata", m1_RDATA, 64'hB0);
    chk("t2_m0_rvalid_off", 64'(m0_RVALID), 0);
    tick;
    beat(64'hB1, 1'b1);
    chk("t2_busy_mid", 64'(busy), 1);
    chk("t2_m1_rlast", 64'(m1_RLAST), 1);
    tick;
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    m0_ARVALID = 1'b1; m1_ARVALID = 1'b1;
    m0_ARADDR = 32'h3000; m0_ARLEN = 8'd3; m0_ARID = 4'd3;
    #1;
    chk("t2_alt_m0_arready", 64'(m0_ARREADY), 1);
    chk("t2_alt_m1_arready", 64'(m1_ARREADY), 0);

    // downstream AR backpressure for 5 cycles
    tick;
    m0_ARVALID = 1'b0; m1_ARVALID = 1'b0; s_ARREADY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_s_arvalid_hold", 64'(s_ARVALID), 1);
      chk("t3_s_araddr_hold", 64'(s_ARADDR), 64'h3000);
      chk("t3_s_arlen_hold", 64'(s_ARLEN), 3);
      tick;
    end
    s_ARREADY = 1'b1;
    #1;
    chk("t3_s_arvalid_c6", 64'(s_ARVALID), 1);
    tick;
    chk("t3_in_data", 64'(s_ARVALID), 0);

    // upstream R backpressure mid-burst
    beat(64'hC0, 1'b0);
    chk("t4_b0_rready", 64'(s_RREADY), 1);
    tick;
    beat(64'hC1, 1'b0);
    m0_RREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_s_rready", 64'(s_RREADY), 0);
      chk("t4_stall_rvalid", 64'(m0_RVALID), 1);
      chk("t4_stall_rdata", m0_RDATA, 64'hC1);
      tick;
    end
    m0_RREADY = 1'b1;
    #1;
    chk("t4_b1_rready", 64'(s_RREADY), 1);
    tick;
    beat(64'hC2, 1'b0);
    tick;
    beat(64'hC3, 1'b1);
    chk("t4_busy_last", 64'(busy), 1);
    chk("t4_b3_rdata", m0_RDATA, 64'hC3);
    tick;
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    #1;
    chk("t4_busy_done", 64'(busy), 0);

    // reset during beat 2 of an 8-beat burst
    m0_ARVALID = 1'b1; m0_ARADDR = 32'h5000; m0_ARLEN = 8'd7;
    tick;
    m0_ARVALID = 1'b0;
    tick;
    beat(64'hD0, 1'b0);
    tick;
    beat(64'hD1, 1'b0);
    tick;
    beat(64'hD2, 1'b0);
    chk("t5_pre_rvalid", 64'(m0_RVALID), 1);
    m1_ARVALID = 1'b1; m1_ARADDR = 32'h4000; m1_ARLEN = 8'd0; m1_ARID = 4'd9;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_m0_rvalid", 64'(m0_RVALID), 0);
    chk("t5_rst_m0_rdata", m0_RDATA, 0);
    chk("t5_rst_s_rready", 64'(s_RREADY), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_s_araddr", 64'(s_ARADDR), 0);
    chk("t5_rst_m1_arready", 64'(m1_ARREADY), 0);
    s_RVALID = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    chk("t5_m1_arready", 64'(m1_ARREADY), 1);
    tick;
    m1_ARVALID = 1'b0;
    #1;
    chk("t5_s_araddr", 64'(s_ARADDR), 64'h4000);
    chk("t5_s_arid", 64'(s_ARID), 9);
    tick;
    beat(64'hE0, 1'b1);
    chk("t5_m1_rvalid", 64'(m1_RVALID), 1);
    chk("t5_m0_rvalid", 64'(m0_RVALID), 0);
    tick;
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    #1;
    chk("t5_busy_done", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: ID_W, 4, AXI ID width on all ports.
REQ-002 Parameter: DATA_W, 64, R data width.
REQ-003 Parameter: FIRST_PRIO, 0, master index holding priority after reset.
REQ-004 io_basic_ACLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 io_basic_ARESETn  in  1  reset, asynchronous, active-low.
REQ-006 m0_ARVALID/m1_ARVALID  in  1  upstream read-address request; m0 = instruction fetch, m1 = data.
REQ-007 m0_ARREADY/m1_ARREADY  out  1  upstream address accept.
REQ-008 m0_/m1_ ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  ID_W, 32, 8, 3, 2  upstream AR payload.
REQ-009 m0_/m1_ RVALID, RID, RDATA, RRESP, RLAST  out  1, ID_W, DATA_W, 2, 1  upstream R channel.
REQ-010 m0_RREADY/m1_RREADY  in  1  upstream R accept.
REQ-011 s_ARVALID, s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST  out  1, ID_W, 32, 8, 3, 2  downstream AR to memory port.
REQ-012 s_ARREADY  in  1  downstream address accept.
REQ-013 s_RVALID, s_RID, s_RDATA, s_RRESP, s_RLAST  in  1, ID_W, DATA_W, 2, 1  downstream R channel.
REQ-014 s_RREADY  out  1  downstream R accept.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, DATA; exactly one burst outstanding downstream at any time.
REQ-017 IDLE: if exactly one mX_ARVALID high, that master SHALL be granted; if both high, the master named by the priority pointer SHALL be granted.
REQ-018 IDLE: granted master's mX_ARREADY SHALL be 1 combinationally in the same cycle; the other master's ARREADY SHALL be 0; ARREADY SHALL be 0 for both in ADDR and DATA.
REQ-019 On the upstream AR handshake the AR payload and grant index SHALL be registered and the FSM SHALL move to ADDR.
REQ-020 ADDR: s_ARVALID SHALL be 1 with the registered payload, unchanged until s_ARREADY; first s_ARVALID cycle is exactly one cycle after the upstream handshake.
REQ-021 On s_ARVALID & s_ARREADY the FSM SHALL move to DATA; s_ARVALID SHALL be 0 outside ADDR.
REQ-022 DATA: s_R* SHALL be forwarded combinationally (zero latency) to the granted master; s_RREADY SHALL equal the granted master's RREADY; the non-granted master's RVALID SHALL be 0.
REQ-023 DATA: on s_RVALID & s_RREADY & s_RLAST the FSM SHALL return to IDLE and the priority pointer SHALL point to the master not just served.
REQ-024 Beats with RLAST=0 SHALL leave state unchanged; no beat counting against ARLEN; RID SHALL be forwarded unchecked.
REQ-025 s_RVALID outside DATA SHALL be ignored (s_RREADY=0, no upstream RVALID).
REQ-026 Upstream AR arriving while not IDLE SHALL be stalled (ARREADY=0) and serviced in a later IDLE cycle; no request is dropped.
REQ-027 After RLAST handshake the FSM SHALL spend at least one cycle in IDLE before a new grant is registered (new grant at IDLE, ADDR next cycle).
REQ-028 A single requester SHALL be granted regardless of pointer; the pointer SHALL still update per REQ-023.

Reset
REQ-029 While io_basic_ARESETn=0: state IDLE, pointer=FIRST_PRIO, registered payload all zero, s_ARVALID=0, s_RREADY=0, mX_RVALID=0, busy=0.
REQ-030 Reset assertion mid-burst SHALL abort immediately (asynchronously); after release the block SHALL accept a fresh request with no residual grant.
REQ-031 mX_ARREADY during reset SHALL be 0.

Verification
REQ-032 m0 only, ARADDR=0x8000_0000, ARLEN=3, s_ARREADY=1 -> s_ARVALID 1 cycle after handshake, 4 beats to m0, m1_RVALID=0 throughout, busy low after last beat.
REQ-033 m0 and m1 request same cycle after reset, FIRST_PRIO=0 -> m0 served first; m1 granted in the IDLE cycle after m0 RLAST; next simultaneous pair -> m0 served (pointer alternates).
REQ-034 s_ARREADY held 0 for 5 cycles -> s_ARVALID and payload stable all 5 cycles, handshake on cycle 6.
REQ-035 Granted master drops RREADY for 3 cycles mid-burst -> s_RREADY=0 same cycles, no beat lost or duplicated.
REQ-036 Spurious s_RVALID=1 in IDLE -> s_RREADY=0, no upstream RVALID.
REQ-037 io_basic_ARESETn pulsed low during beat 2 of ARLEN=7 -> all outputs zero immediately; after release new m1 ARLEN=0 request completes normally.
